// File: rtl/alu_bitserial_seq.sv
// ---------------------------------------------------------------------------
// alu_bitserial_seq
//   Bit-serial ALU sequencer. Two WIDTH-bit operands are latched on the
//   accepting edge. One bit per clock is then processed, LSB first, through
//   a 1-bit logic/adder slice with a carry flip-flop. The full result and
//   its flags are published on the completion edge.
//
//   Ports
//     Clock    : system clock, rising edge
//     Reset    : asynchronous reset, active low
//     Start    : request, sampled only when Busy=0 (IDLE or DONE)
//     ALUOp    : 00 ADD, 01 SUB (A-B), 10 XOR, 11 AND
//     A, B     : operands, sampled on the accepting edge
//     Busy     : high while RUN is in progress
//     Done     : one-cycle pulse; Result and flags are valid
//     Result   : last completed result, held until the next completion
//     Zero     : Result == 0
//     Carry    : ADD carry-out; SUB not-borrow (A >= B unsigned); else 0
//     Overflow : signed overflow for ADD/SUB, else 0
//                (present only when ALU_BITSERIAL_OVERFLOW_EN is defined)
//
//   Configuration macro: ALU_BITSERIAL_OVERFLOW_EN
//   CNT_W must satisfy 2**CNT_W >= WIDTH. The counter never wraps because
//   RUN exits at WIDTH-1.
// ---------------------------------------------------------------------------

// One bit of the datapath. SUB reuses the adder: b is inverted here, and the
// carry FF is preset to 1 at load time.
module alu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [1:0] op,
  output logic       r,
  output logic       c_out
);
  logic bi;

  always_comb begin
    bi    = (op == 2'b01) ? ~b : b;
    r     = 1'b0;
    c_out = c;
    case (op)
      2'b00, 2'b01: begin
        r     = a ^ bi ^ c;
        c_out = (a & bi) | (a & c) | (bi & c);
      end
      2'b10:   r = a ^ b;
      default: r = a & b;
    endcase
  end
endmodule

module alu_bitserial_seq #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry
`ifdef ALU_BITSERIAL_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_SUB = 2'b01;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [WIDTH-1:0] sr_next;
  logic [1:0]       op;
  logic             cy;
  logic             bit_r, bit_c;
  logic             last, arith;

  alu_bit_slice u_slice (
    .a     (sa[0]),
    .b     (sb[0]),
    .c     (cy),
    .op    (op),
    .r     (bit_r),
    .c_out (bit_c)
  );

  // The result bit enters at the MSB. After WIDTH shifts, bit 0 of the
  // operation sits at bit 0 of SR.
  assign sr_next = {bit_r, sr[WIDTH-1:1]};
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign arith   = ~op[1];

  assign Busy = (state == S_RUN);
  assign Done = (state == S_DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      op     <= 2'b00;
      cy     <= 1'b0;
      Result <= '0;
      Zero   <= 1'b0;
      Carry  <= 1'b0;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts Start exactly like IDLE. This gives back-to-back
        // operation with no idle cycle in between.
        S_IDLE, S_DONE: begin
          if (Start) begin
            sa    <= A;
            sb    <= B;
            sr    <= '0;
            op    <= ALUOp;
            cy    <= (ALUOp == OP_SUB);
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (arith) cy <= bit_c;
          if (last) begin
            Result <= sr_next;
            Zero   <= (sr_next == '0);
            Carry  <= arith & bit_c;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
            // cy still holds the carry into the MSB on this edge.
            Overflow <= arith & (cy ^ bit_c);
`endif
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed bench for alu_bitserial_seq. Expected values are hand-computed.
module tb_alu_bitserial_seq;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [23:0] A = '0, B = '0;
  logic        Busy, Done, Zero, Carry;
  logic [23:0] Result;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
  logic        Overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [23:0] prev_res = '0;

  alu_bitserial_seq #(.WIDTH(24), .CNT_W(5)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .ALUOp  (ALUOp),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Zero   (Zero),
    .Carry  (Carry)
`ifdef ALU_BITSERIAL_OVERFLOW_EN
    ,
    .Overflow (Overflow)
`endif
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle and return just after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
    @(negedge Clock);
    ALUOp = op; A = a; B = b; Start = 1'b1;
    @(posedge Clock);
    acc_cyc = cyc + 1;
    #1 Start = 1'b0;
    A = ~a; B = ~b;  // operands may change freely after acceptance
  endtask

  task automatic wait_done(input string tag, input logic [23:0] er, input logic ez,
                           input logic ec, input logic eo);
    while (!Done && (cyc - acc_cyc) < 40) begin
      if ((cyc - acc_cyc) == 12) chk({tag, "_hold"}, Result, prev_res);
      @(posedge Clock); #1;
    end
    chk({tag, "_lat"}, cyc - acc_cyc, 24);
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_res"}, Result, er);
    chk({tag, "_zero"}, Zero, ez);
    chk({tag, "_carry"}, Carry, ec);
`ifdef ALU_BITSERIAL_OVERFLOW_EN
    chk({tag, "_ovf"}, Overflow, eo);
`else
    if (eo) checks = checks + 0;
`endif
    prev_res = er;
  endtask

  task automatic expect_idle(input string tag);
    @(posedge Clock); #1;
    chk({tag, "_pulse"}, {Done, Busy}, 2'b00);
  endtask

  initial begin
    #2;
    chk("rst_out", {Busy, Done, Zero, Carry, Result}, 28'h0);
    @(negedge Clock); Reset = 1'b1;

    start_op(2'b00, 24'h000001, 24'h000002);
    chk("add1_busy", Busy, 1);
    wait_done("add1", 24'h000003, 0, 0, 0);
    expect_idle("add1");

    start_op(2'b00, 24'hFFFFFF, 24'h000001);
    wait_done("addwrap", 24'h000000, 1, 1, 0);
    expect_idle("addwrap");

    start_op(2'b00, 24'h7FFFFF, 24'h000001);
    wait_done("addovf", 24'h800000, 0, 0, 1);
    expect_idle("addovf");

    start_op(2'b01, 24'h000005, 24'h000005);
    wait_done("subeq", 24'h000000, 1, 1, 0);
    expect_idle("subeq");

    start_op(2'b01, 24'h000000, 24'h000001);
    wait_done("subneg", 24'hFFFFFF, 0, 0, 0);
    expect_idle("subneg");

    // XOR, then AND requested while DONE is showing: accepted on that edge.
    start_op(2'b10, 24'hA5A5A5, 24'h5A5A5A);
    wait_done("xor", 24'hFFFFFF, 0, 0, 0);
    ALUOp = 2'b11; A = 24'hA5A5A5; B = 24'h5A5A5A; Start = 1'b1;
    @(posedge Clock);
    acc_cyc = cyc + 1;
    #1 Start = 1'b0;
    chk("b2b_busy", {Busy, Done}, 2'b10);
    chk("b2b_hold", Result, 24'hFFFFFF);
    wait_done("and", 24'h000000, 1, 0, 0);
    expect_idle("and");

    // A second Start during RUN must be ignored.
    start_op(2'b00, 24'h000001, 24'h000002);
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    ALUOp = 2'b01; A = 24'h000100; B = 24'h000300; Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
    wait_done("ign", 24'h000003, 0, 0, 0);
    expect_idle("ign");

    // Asynchronous reset in the middle of RUN.
    start_op(2'b00, 24'h123456, 24'h111111);
    repeat (9) @(posedge Clock);
    #3 Reset = 1'b0;
    #1 chk("arst_out", {Busy, Done, Zero, Carry, Result}, 28'h0);
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;
    chk("arst_idle", {Busy, Done}, 2'b00);
    prev_res = 24'h0;

    start_op(2'b00, 24'h000010, 24'h000020);
    wait_done("post", 24'h000030, 0, 0, 0);
    expect_idle("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_bitserial_seq.md
Name: alu_bitserial_seq

Overview:
- Bit-serial 24-bit ALU sequencer for the datapath.
- Latches two operands and evaluates one bit per clock (LSB first) through 1-bit logic/adder slices with a carry flip-flop.
- Produces a 24-bit result plus Zero/Carry flags, with a Start/Busy/Done handshake.
- Sits between register-file read and write-back; a low-area alternative to the parallel ALU.

Parameters:
- WIDTH, 24: operand/result width in bits.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Start  input  1  request; sampled only when Busy=0.
- ALUOp  input  2  00 ADD, 01 SUB (A-B), 10 XOR, 11 AND.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; Result/flags valid.
- Result  output  WIDTH  last completed result; held until the next completion.
- Zero  output  1  Result == 0.
- Carry  output  1  ADD: carry-out. SUB: not-borrow (1 when A >= B unsigned). XOR/AND: 0.

Behaviour:
- Reset (Reset=0, async): state IDLE; Busy=0, Done=0, Result=0, Zero=0, Carry=0; counter, shift registers and carry FF cleared.
- Reset asserted mid-RUN aborts the operation. No Done is produced and Result is not updated.
- States:
  - IDLE: Start=1 at an edge → load shift regs SA=A, SB=B; carry FF = 1 for SUB, else 0; latch op; counter=0; go to RUN.
  - RUN: each edge processes bit0 of SA/SB.
    - ADD: sum = a^b^c, c' = majority(a,b,c).
    - SUB: b is inverted first, then as ADD.
    - XOR: a^b. AND: a&b. Carry FF is unchanged for XOR/AND.
    - Result bit shifts into the MSB of internal register SR; SA/SB shift right; counter increments.
    - On the edge where counter == WIDTH-1: Result <= final SR value, Zero/Carry updated, go to DONE.
  - DONE: Done=1 for exactly one cycle.
    - Start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no idle cycle.
    - Otherwise go to IDLE.
- Busy=1 only in RUN. Start is ignored while Busy=1; no queuing.
- Latency: Start accepted at edge E → Done high in the cycle after edge E+WIDTH (WIDTH RUN cycles). Throughput: one op per WIDTH+1 cycles.
- Operand inputs may change freely after the accepting edge.
- Result/Zero/Carry change only on the completion edge; they hold stable through RUN of the next op.
- Arithmetic is modulo 2^WIDTH; no sign extension.
- Counter width is CNT_W; no wrap occurs because RUN exits at WIDTH-1.

Optional Feature:
- Macro: ALU_BITSERIAL_OVERFLOW_EN.
- Defined:
  - Extra output Overflow (1 bit, reset 0), updated on the completion edge.
  - ADD/SUB: carry-into-MSB XOR carry-out-of-MSB, i.e. signed two's-complement overflow.
  - XOR/AND: 0.
- Not defined: no Overflow port, no associated logic; all other behaviour is identical.

Test Plan:
- ADD A=0x000001 B=0x000002, Start one cycle → Busy 24 cycles, Done pulse 1 cycle; Result=0x000003, Zero=0, Carry=0.
- ADD A=0xFFFFFF B=0x000001 → Result=0x000000, Zero=1, Carry=1; with macro, Overflow=0. ADD 0x7FFFFF+0x000001 → Result=0x800000, Overflow=1.
- SUB A=0x000005 B=0x000005 → Result=0, Zero=1, Carry=1. SUB A=0x000000 B=0x000001 → Result=0xFFFFFF, Carry=0.
- XOR A=0xA5A5A5 B=0x5A5A5A → Result=0xFFFFFF, Carry=0. Then AND with the same operands, Start held high in DONE → accepted immediately; Result=0x000000, Zero=1.
- Start pulsed again mid-RUN with different A/B → ignored; first result delivered unchanged at the original Done time.
- Reset=0 at RUN cycle 10 → all outputs 0 immediately (async). After release, new ADD 0x000010+0x000020 → Result=0x000030 after the full 24-cycle latency.
